// File: rtl/mic_delay_buf.sv
// mic_delay_buf: multi-channel circular sample buffer with delayed random-access reads
module mic_delay_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int CH     = 4,
  parameter int DLY_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [$clog2(CH)-1:0]    in_ch,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     seq_err,
  output logic                     frame_tick,
  output logic [$clog2(DEPTH)-1:0] fill,
  input  logic                     rd_req,
  input  logic [$clog2(CH)-1:0]    rd_ch,
  input  logic [DLY_W-1:0]         rd_delay,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_stale,
  output logic                     rd_clamp
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(CH);
  logic [DATA_W-1:0] ram [CH*DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [PW-1:0] wr_ptr, d_eff;
  logic [CW-1:0] exp_ch;
  logic [PW+CW-1:0] raddr;
  logic wr_ok, last, clamp, stale, s1_v, s1_stale, s1_clamp;
  always_comb begin
    wr_ok = in_valid && in_ch == exp_ch && !flush;
    last  = wr_ok && in_ch == CW'(CH - 1);
    clamp = rd_delay > DLY_W'(DEPTH - 2);
    d_eff = clamp ? PW'(DEPTH - 2) : rd_delay[PW-1:0];
    stale = d_eff >= fill;
    raddr = {wr_ptr - PW'(1) - d_eff, rd_ch};
  end
  // RAM kept free of reset so it maps onto a block RAM with registered output
  always_ff @(posedge clk) begin
    if (wr_ok) ram[{wr_ptr, in_ch}] <= in_data;
    if (rd_req) ram_q <= ram[raddr];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      exp_ch     <= '0;
      fill       <= '0;
      seq_err    <= 1'b0;
      frame_tick <= 1'b0;
      s1_v       <= 1'b0;
      s1_stale   <= 1'b0;
      s1_clamp   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_stale   <= 1'b0;
      rd_clamp   <= 1'b0;
    end else begin
      seq_err    <= in_valid && in_ch != exp_ch && !flush;
      frame_tick <= last;
      s1_v       <= rd_req && !flush;
      s1_stale   <= stale;
      s1_clamp   <= clamp;
      rd_valid   <= s1_v;
      rd_data    <= (s1_v && !s1_stale) ? ram_q : '0;
      rd_stale   <= s1_v && s1_stale;
      rd_clamp   <= s1_v && s1_clamp;
      if (flush) begin
        wr_ptr <= '0;
        exp_ch <= '0;
        fill   <= '0;
      end else if (wr_ok) begin
        exp_ch <= last ? '0 : exp_ch + CW'(1);
        if (last) begin
          wr_ptr <= wr_ptr + PW'(1);
          fill   <= fill + PW'(fill != '1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mic_delay_buf.sv
// tb_mic_delay_buf: directed stimulus with a read scoreboard and a decoupled monitor
module tb_mic_delay_buf;
  logic clk = 1'b0;
  logic reset, flush, in_valid, rd_req;
  logic [1:0] in_ch, rd_ch;
  logic [15:0] in_data;
  logic [9:0] rd_delay;
  logic seq_err, frame_tick, rd_valid, rd_stale, rd_clamp;
  logic [3:0] fill;
  logic [15:0] rd_data;
  typedef struct {logic [15:0] d; logic s; logic c;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, nf = 0, run = 0, max_run = 0;

  mic_delay_buf #(.DATA_W(16), .DEPTH(16), .CH(4), .DLY_W(10)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .seq_err(seq_err), .frame_tick(frame_tick), .fill(fill),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_delay(rd_delay), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_stale(rd_stale), .rd_clamp(rd_clamp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  task automatic cyc(input bit wv, input int wc, input int wd, input bit rv, input int rc,
                     input int dl, input bit fl = 0);
    in_valid = wv; in_ch = 2'(wc); in_data = 16'(wd);
    rd_req = rv; rd_ch = 2'(rc); rd_delay = 10'(dl); flush = fl;
    @(posedge clk); #1;
    in_valid = 0; rd_req = 0; flush = 0;
    if (fl) nf = 0;
    else if (wv && wc == 3) nf++;
  endtask

  task automatic push(input int d, input bit s, input bit c);
    exp_t e;
    e.d = 16'(d); e.s = s; e.c = c;
    sb.push_back(e);
  endtask

  task automatic rd(input int c, input int dl, input int d, input bit s, input bit cl);
    push(d, s, cl);
    cyc(0, 0, 0, 1, c, dl);
  endtask

  task automatic write_frame(input int f);
    for (int c = 0; c < 4; c++) cyc(1, c, 256 * f + c, 0, 0, 0);
    chk("frame_tick", frame_tick, 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected got data %0h stale %0b clamp %0b exp none", rd_data, rd_stale, rd_clamp);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_resp", {rd_data, 14'd0, rd_stale, rd_clamp}, {e.d, 14'd0, e.s, e.c});
        end
      end else begin
        run = 0;
        chk("rd_idle_zero", {rd_data, rd_stale, rd_clamp}, 0);
      end
    end
  end

  initial begin
    reset = 1; flush = 0; in_valid = 0; in_ch = 0; in_data = 0; rd_req = 0; rd_ch = 0; rd_delay = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_fill", fill, 0);
    chk("reset_outs", {frame_tick, seq_err, rd_valid}, 0);
    for (int f = 0; f < 3; f++) write_frame(f);
    chk("fill3", fill, 3);
    rd(2, 0, 16'h0202, 0, 0);
    rd(1, 2, 16'h0001, 0, 0);
    rd(0, 3, 0, 1, 0);
    rd(3, 20, 0, 1, 1);
    cyc(1, 0, 16'h0300, 0, 0, 0);
    cyc(1, 2, 16'hDEAD, 0, 0, 0);
    chk("seq_err_pulse", seq_err, 1);
    cyc(1, 1, 16'h0301, 0, 0, 0);
    chk("seq_err_clear", seq_err, 0);
    cyc(1, 2, 16'h0302, 0, 0, 0);
    cyc(1, 3, 16'h0303, 0, 0, 0);
    chk("seq_frame_tick", frame_tick, 1);
    chk("fill4", fill, 4);
    rd(2, 0, 16'h0302, 0, 0);
    for (int f = 4; f < 40; f++) write_frame(f);
    chk("fill_sat", fill, 15);
    rd(3, 14, 16'h1903, 0, 0);
    rd(0, 0, 16'h2700, 0, 0);
    rd(1, 15, 16'h1901, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      push(256 * (nf - 1) + (3 - i % 4), 0, 0);
      cyc(1, i % 4, 256 * (40 + i / 4) + i % 4, 1, 3 - i % 4, 0);
    end
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    chk("b2b_run", max_run >= 8, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    reset = 1; nf = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {rd_valid, rd_data, rd_stale, rd_clamp, frame_tick, seq_err, fill}, 0);
    reset = 0;
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    chk("rst_no_valid", rd_valid, 0);
    for (int f = 0; f < 5; f++) write_frame(f);
    chk("fill5", fill, 5);
    cyc(1, 0, 16'hBEEF, 1, 0, 0, 1);
    chk("flush_fill", fill, 0);
    rd(0, 0, 0, 1, 0);
    for (int c = 0; c < 4; c++) cyc(1, c, 16'h3000 + c, 0, 0, 0);
    chk("post_flush_tick", frame_tick, 1);
    rd(1, 0, 16'h3001, 0, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(0, 0, 0, 0, 0, 0);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
